// File: rtl/sm4_round_key_server.sv
// SM4 key schedule engine: expands a 128-bit master key over 32 cycles into a round-key
// buffer, then streams rk0..rk31 forward or reverse. Optional key_clr port: SM4_KEY_ZEROIZE_EN.

module sm4_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [7:0] SBOX [256] = '{
        8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
        8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
        8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
        8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
        8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
        8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
        8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
        8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
        8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
        8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
        8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
        8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
        8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
        8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
        8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
        8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
    };
    assign y = SBOX[a];
endmodule

// One key-schedule round: {K0,K1,K2,K3} -> {K1,K2,K3,K0 ^ L'(tau(K1^K2^K3^CK))}.
module round_key_expansion (
    input  logic [127:0] data,
    input  logic [31:0]  cki,
    output logic [127:0] result
);
    logic [31:0] x, t, l;

    assign x = data[95:64] ^ data[63:32] ^ data[31:0] ^ cki;

    for (genvar j = 0; j < 4; j++) begin : g_sbox
        sm4_sbox u_sbox (.a(x[8*j +: 8]), .y(t[8*j +: 8]));
    end

    assign l      = t ^ {t[18:0], t[31:19]} ^ {t[8:0], t[31:9]};
    assign result = {data[95:0], data[127:96] ^ l};
endmodule

module sm4_round_key_server #(
    parameter int NRK   = 32,
    parameter int IDX_W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    input  logic [127:0] key,
    output logic         key_ready,
    output logic         keys_valid,
    input  logic         rk_start,
    input  logic         rk_dec,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [31:0]  rk_data,
    output logic [IDX_W-1:0] rk_idx,
`ifdef SM4_KEY_ZEROIZE_EN
    input  logic         key_clr,
`endif
    output logic         rk_last
);
    localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NRK - 1);

    typedef enum logic [1:0] {IDLE, EXPAND, READY, STREAM} state_t;

    state_t             state, state_nxt;
    logic [127:0]       kreg, kres;
    logic [IDX_W-1:0]   cnt, idx;
    logic               dec;
    logic [31:0]        rkbuf [NRK];
    logic [31:0]        cki;
    logic               clr, accept, at_last;

`ifdef SM4_KEY_ZEROIZE_EN
    assign clr = key_clr;
`else
    assign clr = 1'b0;
`endif

    // CK byte j of round i is ((4*i+j)*7) mod 256; the 8-bit product wraps naturally.
    for (genvar j = 0; j < 4; j++) begin : g_ck
        assign cki[31-8*j -: 8] = 8'({1'b0, cnt, 2'(j)} * 8'd7);
    end

    round_key_expansion u_rke (.data(kreg), .cki(cki), .result(kres));

    assign accept  = key_valid && key_ready;
    assign at_last = dec ? (idx == '0) : (idx == IDX_MAX);

    always_comb begin
        state_nxt  = state;
        key_ready  = 1'b0;
        keys_valid = 1'b0;
        rk_valid   = 1'b0;
        case (state)
            IDLE: begin
                key_ready = 1'b1;
                if (key_valid) state_nxt = EXPAND;
            end
            EXPAND: if (cnt == IDX_MAX) state_nxt = READY;
            READY: begin
                key_ready  = 1'b1;
                keys_valid = 1'b1;
                if (key_valid)     state_nxt = EXPAND;
                else if (rk_start) state_nxt = STREAM;
            end
            STREAM: begin
                keys_valid = 1'b1;
                rk_valid   = 1'b1;
                if (rk_ready && at_last) state_nxt = READY;
            end
            default: state_nxt = IDLE;
        endcase
        if (clr) state_nxt = IDLE;
    end

    assign rk_data = rk_valid ? rkbuf[idx] : 32'h0;
    assign rk_idx  = rk_valid ? idx : '0;
    assign rk_last = rk_valid && at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kreg <= '0;
            cnt  <= '0;
            idx  <= '0;
            dec  <= 1'b0;
            for (int i = 0; i < NRK; i++) rkbuf[i] <= '0;
        end else if (clr) begin
            kreg <= '0;
            cnt  <= '0;
            idx  <= '0;
            dec  <= 1'b0;
            for (int i = 0; i < NRK; i++) rkbuf[i] <= '0;
        end else begin
            case (state)
                IDLE, READY: begin
                    if (accept) begin
                        kreg <= key ^ FK;
                        cnt  <= '0;
                    end else if (state == READY && rk_start) begin
                        idx <= rk_dec ? IDX_MAX : '0;
                        dec <= rk_dec;
                    end
                end
                EXPAND: begin
                    kreg       <= kres;
                    rkbuf[cnt] <= kres[31:0];
                    cnt        <= cnt + 1'b1;
                end
                STREAM: begin
                    if (rk_ready && !at_last) idx <= dec ? idx - 1'b1 : idx + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
